srl_fifo_ctrl: RTL and testbench
================================

# srl_fifo_ctrl

Synchronous FIFO built on a clock-enabled, addressable shift register. Sequences the shift enable and read address so the datapath maps onto SRL16E primitives, and presents valid/ready handshakes on both sides. Sits between a streaming producer and consumer wherever a shallow (≤16 entry) elastic buffer is needed at LUT cost instead of block RAM.

## Interface
- WIDTH, 8, data bits per entry
- DEPTH, 16, shift-register entries; power of two, 2..16
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset of all control state
- flush  in  1  synchronous clear of FIFO contents
- s_valid  in  1  producer has data
- s_ready  out  1  FIFO can accept data
- s_data  in  WIDTH  write data
- m_valid  out  1  head entry valid
- m_ready  in  1  consumer accepts head
- m_data  out  WIDTH  head entry data
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH (+1 with output register)

## Operation
- Push = s_valid & s_ready; pop = m_valid & m_ready.
- Push asserts shift enable: entries move one place up, s_data enters at index 0. No other shift.
- Oldest entry lives at index count-1; read address = count-1, truncated to address width.
- Occupancy update: push only → +1; pop only → −1; push and pop → unchanged (shift and pop cancel in the address).
- Control FSM, states EMPTY, PARTIAL, FULL:
  - EMPTY → PARTIAL on push; PARTIAL → FULL on push-only at count=DEPTH-1; PARTIAL → EMPTY on pop-only at count=1; FULL → PARTIAL on pop.
  - Any state → EMPTY on flush.
- s_ready = (state != FULL) & !flush. It has no combinational dependency on m_ready; a full FIFO does not accept same-cycle push-through.
- m_valid = (state != EMPTY) & !flush.
- m_data is don't-care while m_valid=0; not gated.
- flush takes priority over push and pop in the same cycle. Data in flight is dropped; shift-register contents are not cleared.
- Shift-register storage has no reset and no flush path, so it keeps mapping to SRL16E.
- Reset mid-operation: control state returns to EMPTY immediately. Stored data is abandoned.

## Timing
- Reset values: s_ready=1, m_valid=0, count=0, state=EMPTY. m_data is undefined.
- Write-to-read latency: push at edge t gives m_valid=1 after edge t, with m_data valid in the same cycle (combinational SRL read).
- Throughput: one push and one pop per cycle sustained at any occupancy except FULL push-through.
- Flush: asserted in cycle t gives count=0 and m_valid=0 after edge t.

## Configuration
- SRL_FIFO_OUTREG_EN
  - Defined:
    - A reset-able output register holds the head.
    - It loads from the SRL when the register is empty or popped and the SRL is non-empty.
    - m_data is driven from flops.
    - Capacity becomes DEPTH+1 and write-to-read latency becomes 2 cycles.
    - count includes the register entry.
    - Flush also clears the register valid bit.
  - Undefined: behaviour as described above.

## Structure
- Package srl_fifo_pkg holds:
  - the FSM state enum type
  - MAX_DEPTH=16 (SRL16E limit)
  - a function computing the address width from DEPTH
- Sub-module srl_shift(WIDTH, DEPTH):
  - ports clk, ce, addr, d, q
  - no reset, negligible logic besides the shift array
  - synthesis of srl_shift must yield WIDTH SRL16E cells and no other cells

## Test plan
- Reset with s_valid=1 held → s_ready=1, m_valid=0, count=0 during and one cycle after rst_n release; first push lands at the following edge.
- Push 0x11,0x22,0x33, then pop three → m_data sequence 0x11,0x22,0x33; count 3→0; m_valid low after the last pop.
- Fill 16 entries 0x00..0x0F → s_ready=0 and state FULL. Extra push of 0xAA is not accepted. Pop returns 0x00, then s_ready=1.
- Continuous push+pop for 64 cycles at count=5 → count stays 5 and data order is preserved (incrementing pattern).
- Flush at count=7, asserted together with a push of 0x55 → count=0 and m_valid=0 next cycle; 0x55 never appears at output.
- With SRL_FIFO_OUTREG_EN: push 0x42 into empty FIFO → m_valid rises 2 cycles later; 17 pushes accepted before s_ready=0.

Source files
------------

// File: rtl/srl_fifo_pkg.sv
// Shared types and helpers for the SRL16E-based FIFO controller.
// Optional output register is selected with the SRL_FIFO_OUTREG_EN macro.
package srl_fifo_pkg;

    // Deepest shift register a single SRL16E can implement
    localparam int MAX_DEPTH = 16;

    // Occupancy state of the shift-register part of the FIFO
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } fifo_state_e;

    // Read-address width for a given depth, clamped to the SRL16E limit
    function automatic int srl_addr_width(input int depth);
        int d;
        d = (depth > MAX_DEPTH) ? MAX_DEPTH : depth;
        if (d <= 2) begin
            return 1;
        end else begin
            return $clog2(d);
        end
    endfunction

endpackage

// File: rtl/srl_fifo_ctrl_srl_shift.sv
// Clock-enabled addressable shift register. Deliberately has no reset and
// no clear path so that each data bit maps onto a single SRL16E cell.
module srl_shift
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              ce,
    input  logic [srl_addr_width(DEPTH)-1:0]  addr,
    input  logic [WIDTH-1:0]                  d,
    output logic [WIDTH-1:0]                  q
);

    logic [WIDTH-1:0] sr_r [DEPTH];

    // Shift every entry up one place and insert new data at index 0
    always_ff @(posedge clk) begin
        if (ce) begin
            sr_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr_r[i] <= sr_r[i-1];
            end
        end
    end

    assign q = sr_r[addr];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// FIFO controller around an SRL16E shift register: push shifts data in at
// index 0, the oldest entry is read at index count-1.
// Optional head output register: define SRL_FIFO_OUTREG_EN.
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = srl_addr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE_C      = CW'(1'b1);
    localparam logic [CW-1:0] ZERO_C     = CW'(1'b0);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

    fifo_state_e      state_r;
    logic [CW-1:0]    srl_cnt_r;
    logic [AW-1:0]    rd_addr_s;
    logic [WIDTH-1:0] srl_q_s;
    logic             push_s;
    logic             pop_s;
    logic             srl_pop_s;

    // Handshakes; flush blocks both sides so in-flight data is dropped
    assign s_ready   = (state_r != ST_FULL) & ~flush;
    assign push_s    = s_valid & s_ready;
    assign pop_s     = m_valid & m_ready;
    assign rd_addr_s = AW'(srl_cnt_r - ONE_C);

`ifdef SRL_FIFO_OUTREG_EN
    logic             out_vld_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CW-1:0]    tot_cnt_r;

    // Head register refills from the SRL whenever it is empty or being popped
    assign srl_pop_s = (state_r != ST_EMPTY) & (~out_vld_r | pop_s) & ~flush;
    assign m_valid   = out_vld_r & ~flush;
    assign m_data    = out_data_r;
    assign count     = tot_cnt_r;

    // Output register holding the FIFO head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_r  <= 1'b0;
            out_data_r <= '0;
        end else if (flush) begin
            out_vld_r  <= 1'b0;
        end else if (srl_pop_s) begin
            out_vld_r  <= 1'b1;
            out_data_r <= srl_q_s;
        end else if (pop_s) begin
            out_vld_r  <= 1'b0;
        end
    end

    // Total occupancy including the head register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot_cnt_r <= ZERO_C;
        end else if (flush) begin
            tot_cnt_r <= ZERO_C;
        end else begin
            case ({push_s, pop_s})
                2'b10:   tot_cnt_r <= tot_cnt_r + ONE_C;
                2'b01:   tot_cnt_r <= tot_cnt_r - ONE_C;
                default: tot_cnt_r <= tot_cnt_r;
            endcase
        end
    end
`else
    // The SRL head is the FIFO head: combinational read, one-cycle latency
    assign srl_pop_s = pop_s;
    assign m_valid   = (state_r != ST_EMPTY) & ~flush;
    assign m_data    = srl_q_s;
    assign count     = srl_cnt_r;
`endif

    // Control FSM and SRL occupancy; push+pop cancel in the read address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_EMPTY;
            srl_cnt_r <= ZERO_C;
        end else if (flush) begin
            state_r   <= ST_EMPTY;
            srl_cnt_r <= ZERO_C;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_r   <= ST_PARTIAL;
                        srl_cnt_r <= srl_cnt_r + ONE_C;
                    end else begin
                        state_r   <= ST_EMPTY;
                    end
                end
                ST_PARTIAL: begin
                    if (push_s && !srl_pop_s) begin
                        srl_cnt_r <= srl_cnt_r + ONE_C;
                        state_r   <= (srl_cnt_r == DEPTH_M1_C) ? ST_FULL : ST_PARTIAL;
                    end else if (!push_s && srl_pop_s) begin
                        srl_cnt_r <= srl_cnt_r - ONE_C;
                        state_r   <= (srl_cnt_r == ONE_C) ? ST_EMPTY : ST_PARTIAL;
                    end else begin
                        state_r   <= ST_PARTIAL;
                    end
                end
                ST_FULL: begin
                    if (srl_pop_s) begin
                        state_r   <= ST_PARTIAL;
                        srl_cnt_r <= srl_cnt_r - ONE_C;
                    end else begin
                        state_r   <= ST_FULL;
                    end
                end
                default: begin
                    state_r   <= ST_EMPTY;
                    srl_cnt_r <= ZERO_C;
                end
            endcase
        end
    end

    srl_shift #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_srl (
        .clk  (clk),
        .ce   (push_s),
        .addr (rd_addr_s),
        .d    (s_data),
        .q    (srl_q_s)
    );

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Scoreboard bench for srl_fifo_ctrl: stimulus queues expected head data,
// a negedge monitor compares every accepted pop against the queue.
module tb_srl_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SRL_FIFO_OUTREG_EN
    localparam int CAP = DEPTH + 1;
`else
    localparam int CAP = DEPTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CW-1:0]    count;

    int n_chk;
    int n_pass;
    logic [WIDTH-1:0] exp_q [$];

    srl_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: every handshake seen before the edge must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {24'h0, m_data}, 32'hFFFF_FFFF);
            end else begin
                chk("m_data", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        exp_q.push_back(d);
        step();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard   = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 100) begin
            step();
            guard++;
        end
        m_ready = 1'b0;
        if (guard >= 100) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h42;
        m_ready = 1'b0;

        // Reset with s_valid held high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", {31'h0, s_ready}, 32'd1);
        chk("rst_m_valid", {31'h0, m_valid}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready", {31'h0, s_ready}, 32'd1);
        chk("rel_m_valid", {31'h0, m_valid}, 32'd0);
        chk("rel_count", 32'(count), 32'd0);
        exp_q.push_back(8'h42);
        step();
        s_valid = 1'b0;
        chk("first_push_count", 32'(count), 32'd1);
`ifdef SRL_FIFO_OUTREG_EN
        chk("lat_m_valid_t1", {31'h0, m_valid}, 32'd0);
        step();
        chk("lat_m_valid_t2", {31'h0, m_valid}, 32'd1);
`else
        chk("lat_m_valid_t1", {31'h0, m_valid}, 32'd1);
`endif
        drain();
        chk("after_drain_valid", {31'h0, m_valid}, 32'd0);

        // Three pushes, three pops
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("three_count", 32'(count), 32'd3);
        m_ready = 1'b1;
        step();
        chk("pop1_count", 32'(count), 32'd2);
        step();
        chk("pop2_count", 32'(count), 32'd1);
        step();
        m_ready = 1'b0;
        chk("pop3_count", 32'(count), 32'd0);
        chk("pop3_m_valid", {31'h0, m_valid}, 32'd0);

        // Fill to capacity, reject an extra push
        for (int i = 0; i < CAP; i++) begin
            push(8'(i));
        end
        chk("full_s_ready", {31'h0, s_ready}, 32'd0);
        chk("full_count", 32'(count), 32'(CAP));
        s_valid = 1'b1;
        s_data  = 8'hAA;
        step();
        s_valid = 1'b0;
        chk("full_reject_count", 32'(count), 32'(CAP));
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("after_pop_s_ready", {31'h0, s_ready}, 32'd1);
        chk("after_pop_count", 32'(count), 32'(CAP - 1));
        drain();

        // Sustained push+pop at occupancy 5
        for (int i = 0; i < 5; i++) begin
            push(8'(i));
        end
        chk("steady_start_count", 32'(count), 32'd5);
        m_ready = 1'b1;
        for (int i = 5; i < 69; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            exp_q.push_back(8'(i));
            step();
            chk("steady_count", 32'(count), 32'd5);
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        drain();

        // Flush at count 7 together with a push of 0x55
        for (int i = 0; i < 7; i++) begin
            push(8'h70 + 8'(i));
        end
        chk("preflush_count", 32'(count), 32'd7);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        #1;
        chk("flush_s_ready", {31'h0, s_ready}, 32'd0);
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_m_valid", {31'h0, m_valid}, 32'd0);
        push(8'h66);
        drain();
        chk("end_count", 32'(count), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
